// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: memory handshakes, load-use indices, redirect in;
// pipeline register enables/flushes and the stale-fetch discard flag out.
interface pipe_hazard_ctrl_if #(
   parameter int REG_W = 5
);
   logic             i_valid;
   logic             i_data_ok;
   logic             d_valid;
   logic             d_data_ok;
   logic             e_mem_read;
   logic [REG_W-1:0] e_rd;
   logic [REG_W-1:0] d_rs1;
   logic [REG_W-1:0] d_rs2;
   logic             e_redirect;

   logic             enable_f;
   logic             enable_d;
   logic             enable_e;
   logic             enable_m;
   logic             enable_w;
   logic             flush_d;
   logic             flush_e;
   logic             flush_m;
   logic             flush_w;
   logic             i_discard;

   modport master (
      output i_valid, i_data_ok, d_valid, d_data_ok, e_mem_read,
             e_rd, d_rs1, d_rs2, e_redirect,
      input  enable_f, enable_d, enable_e, enable_m, enable_w,
             flush_d, flush_e, flush_m, flush_w, i_discard
   );

   modport slave (
      input  i_valid, i_data_ok, d_valid, d_data_ok, e_mem_read,
             e_rd, d_rs1, d_rs2, e_redirect,
      output enable_f, enable_d, enable_e, enable_m, enable_w,
             flush_d, flush_e, flush_m, flush_w, i_discard
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with stale-fetch tracking.
// Optional performance counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]  cnt_dstall,
   output logic [CNT_W-1:0]  cnt_istall,
   output logic [CNT_W-1:0]  cnt_lu,
   output logic [CNT_W-1:0]  cnt_redirect
`endif
);

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_WAIT = 2'd1,
      F_DROP = 2'd2
   } fstate_t;

   fstate_t r_state;
   fstate_t w_state_next;

   logic w_imiss;
   logic w_dmiss;
   logic w_lu;
   logic w_br_dmiss;
   logic w_br_redir;
   logic w_br_lu;
   logic w_br_imiss;

   if (REG_W < 1 || CNT_W < 1) begin : g_bad_param
      $error("pipe_hazard_ctrl: REG_W and CNT_W must be positive");
   end

   assign w_imiss = (r_state == F_IDLE && hz.i_valid && !hz.i_data_ok) ||
                    (r_state == F_WAIT && !hz.i_data_ok) ||
                    (r_state == F_DROP);
   assign w_dmiss = hz.d_valid && !hz.d_data_ok;
   assign w_lu    = hz.e_mem_read && (hz.e_rd != '0) &&
                    ((hz.e_rd == hz.d_rs1) || (hz.e_rd == hz.d_rs2));

   // One-hot active priority branch; a redirect is only accepted when E can move.
   assign w_br_dmiss = w_dmiss;
   assign w_br_redir = hz.e_redirect && !w_dmiss;
   assign w_br_lu    = w_lu && !w_dmiss && !hz.e_redirect;
   assign w_br_imiss = w_imiss && !w_dmiss && !hz.e_redirect && !w_lu;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= F_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         F_IDLE: begin
            if (hz.i_valid && !hz.i_data_ok) begin
               w_state_next = w_br_redir ? F_DROP : F_WAIT;
            end
         end
         F_WAIT: begin
            if (hz.i_data_ok) begin
               w_state_next = F_IDLE;
            end else if (w_br_redir) begin
               w_state_next = F_DROP;
            end
         end
         F_DROP: begin
            if (hz.i_data_ok) begin
               w_state_next = F_IDLE;
            end
         end
         default: w_state_next = F_IDLE;
      endcase
   end

   always_comb begin
      hz.enable_f  = 1'b1;
      hz.enable_d  = 1'b1;
      hz.enable_e  = 1'b1;
      hz.enable_m  = 1'b1;
      hz.enable_w  = 1'b1;
      hz.flush_d   = 1'b0;
      hz.flush_e   = 1'b0;
      hz.flush_m   = 1'b0;
      hz.flush_w   = 1'b0;
      hz.i_discard = 1'b0;
      if (reset) begin
         hz.enable_f = 1'b0;
         hz.enable_d = 1'b0;
         hz.enable_e = 1'b0;
         hz.enable_m = 1'b0;
         hz.enable_w = 1'b0;
         hz.flush_d  = 1'b1;
         hz.flush_e  = 1'b1;
         hz.flush_m  = 1'b1;
         hz.flush_w  = 1'b1;
      end else begin
         hz.i_discard = (r_state == F_DROP);
         if (w_br_dmiss) begin
            // W takes a bubble so the frozen M instruction is not committed twice.
            hz.enable_f = 1'b0;
            hz.enable_d = 1'b0;
            hz.enable_e = 1'b0;
            hz.enable_m = 1'b0;
            hz.flush_w  = 1'b1;
         end else if (w_br_redir) begin
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
         end else if (w_br_lu) begin
            hz.enable_f = 1'b0;
            hz.enable_d = 1'b0;
            hz.flush_e  = 1'b1;
         end else if (w_br_imiss) begin
            hz.enable_f = 1'b0;
            hz.flush_d  = 1'b1;
         end
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [3:0] w_cnt_inc;
   assign w_cnt_inc = {w_br_redir, w_br_lu, w_br_imiss, w_br_dmiss};

   for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_cnt <= '0;
         end else if (w_cnt_inc[gi]) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign cnt_dstall   = g_cnt[0].r_cnt;
   assign cnt_istall   = g_cnt[1].r_cnt;
   assign cnt_lu       = g_cnt[2].r_cnt;
   assign cnt_redirect = g_cnt[3].r_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed enable/flush/discard vectors.
// Counter checks are compiled in when PIPE_HAZARD_CTRL_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
   localparam int REG_W = 5;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 32;
`endif

   // {en_f,en_d,en_e,en_m,en_w, fl_d,fl_e,fl_m,fl_w, discard}
   localparam logic [9:0] V_RST   = 10'b00000_1111_0;
   localparam logic [9:0] V_IDLE  = 10'b11111_0000_0;
   localparam logic [9:0] V_LU    = 10'b00111_0100_0;
   localparam logic [9:0] V_IMISS = 10'b01111_1000_0;
   localparam logic [9:0] V_REDIR = 10'b11111_1100_0;
   localparam logic [9:0] V_DMISS = 10'b00001_0001_0;
   localparam logic [9:0] V_DROP  = 10'b01111_1000_1;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   logic [9:0] obs;

   pipe_hazard_ctrl_if #(.REG_W(REG_W)) hz ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] cnt_dstall, cnt_istall, cnt_lu, cnt_redirect;
`endif

   pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .hz           (hz)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      ,
      .cnt_dstall   (cnt_dstall),
      .cnt_istall   (cnt_istall),
      .cnt_lu       (cnt_lu),
      .cnt_redirect (cnt_redirect)
`endif
   );

   assign obs = {hz.enable_f, hz.enable_d, hz.enable_e, hz.enable_m, hz.enable_w,
                 hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w, hz.i_discard};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic iv, input logic iok, input logic dv, input logic dok,
                         input logic mr, input logic [REG_W-1:0] rd,
                         input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                         input logic redir);
      hz.i_valid    = iv;
      hz.i_data_ok  = iok;
      hz.d_valid    = dv;
      hz.d_data_ok  = dok;
      hz.e_mem_read = mr;
      hz.e_rd       = rd;
      hz.d_rs1      = rs1;
      hz.d_rs2      = rs2;
      hz.e_redirect = redir;
   endtask

   task automatic chk(input string tag, input logic [9:0] exp_v);
      #1;
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
      $display("vec %0d %-16s obs=%b exp=%b", vectors, tag, obs, exp_v);
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
      $display("vec %0d %-16s obs=%0d exp=%0d", vectors, tag, o, e);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      chk("reset_hold", V_RST);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc();
      chk("idle_after_rst", V_IDLE);

      // Load-use
      set_in(0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 0);  chk("lu_rs2", V_LU);     cyc();
      set_in(0, 0, 0, 0, 0, 5'd9, 5'd3, 5'd5, 0);  chk("lu_release", V_IDLE); cyc();
      set_in(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0);  chk("lu_rs1", V_LU);     cyc();
      set_in(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);  chk("lu_x0", V_IDLE);    cyc();
      set_in(0, 0, 0, 0, 0, 5'd4, 5'd4, 5'd4, 0);  chk("lu_noload", V_IDLE); cyc();

      // Fetch hit, then a 3-cycle instruction miss
      set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("ihit", V_IDLE);     cyc();
      set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("imiss_1", V_IMISS); cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("imiss_2", V_IMISS); cyc();
      chk("imiss_3", V_IMISS); cyc();
      set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("imiss_resp", V_IDLE); cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("imiss_after", V_IDLE); cyc();

      // Redirect while a fetch is outstanding: response in cycle 4 is dropped
      set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("rd_req", V_IMISS);  cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);  chk("rd_c1", V_REDIR);   cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("rd_c2", V_DROP);    cyc();
      chk("rd_c3", V_DROP); cyc();
      set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("rd_c4", V_DROP);    cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("rd_c5", V_IDLE);    cyc();

      // Redirect in the same cycle the request misses from idle
      set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);  chk("rdi_c1", V_REDIR);  cyc();
      set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("rdi_drop", V_DROP); cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("rdi_idle", V_IDLE); cyc();

      // Data miss holding redirect and load-use off; fetch outstanding meanwhile
      set_in(1, 0, 1, 0, 1, 5'd5, 5'd5, 5'd1, 1);  chk("dm_c1", V_DMISS);   cyc();
      set_in(0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd1, 1);  chk("dm_c2", V_DMISS);   cyc();
      set_in(0, 1, 1, 1, 1, 5'd5, 5'd5, 5'd1, 1);  chk("dm_redir", V_REDIR); cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("dm_after", V_IDLE); cyc();
      set_in(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);  chk("dhit", V_IDLE);     cyc();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk_cnt("cnt_dstall", 32'(cnt_dstall), 32'd2);
      chk_cnt("cnt_istall", 32'(cnt_istall), 32'd8);
      chk_cnt("cnt_lu", 32'(cnt_lu), 32'd2);
      chk_cnt("cnt_redirect", 32'(cnt_redirect), 32'd3);
`endif

      // Eight miss cycles: takes a 4-bit istall counter from 8 through 15 to 0
      set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("long_miss_0", V_IMISS); cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      for (int k = 1; k < 8; k++) begin
         chk("long_miss", V_IMISS);
         cyc();
      end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk_cnt("istall_wrap", 32'(cnt_istall), 32'd0);
`endif
      set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("long_resp", V_IDLE); cyc();

      // Asynchronous reset in the middle of F_WAIT
      set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("mr_req", V_IMISS);  cyc();
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("mr_wait", V_IMISS);
      #2;
      reset = 1'b1;
      chk("mr_async_rst", V_RST);
      @(negedge clk);
      reset = 1'b0;
      cyc();
      chk("mr_idle", V_IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk_cnt("rst_dstall", 32'(cnt_dstall), 32'd0);
      chk_cnt("rst_redirect", 32'(cnt_redirect), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
